// File: rtl/counter_input_ctrl.sv
// counter_input_ctrl: pushbutton front-end for the up/down ping-pong counter.
// Each raw button is synchronised, debounced by a small FSM plus counter, and
// every clean press toggles a level output (x = speed, switch = direction) and
// emits a one-cycle event pulse. lock freezes outputs and pulses but not the
// debouncers, so a press accepted under lock is consumed, not deferred.
module counter_input_ctrl #(
   parameter int unsigned DB_CYCLES = 4,     // stable cycles to accept press/release (>=2)
   parameter int unsigned CNT_W     = 8,     // 2**CNT_W must exceed DB_CYCLES
   parameter bit          X_INIT    = 1'b0,
   parameter bit          SW_INIT   = 1'b0
) (
   input  logic clk_1,
   input  logic rst,
   input  logic btn_speed,
   input  logic btn_dir,
   input  logic lock,
   output logic x,
   output logic switch,
   output logic speed_evt,
   output logic dir_evt
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [1:0]       LVL_INIT = {SW_INIT, X_INIT};

   // Channel 0 is the speed button, channel 1 the direction button.
   logic [1:0] btn;
   logic [1:0] lvl;
   logic [1:0] evt;

   assign btn = {btn_dir, btn_speed};

   for (genvar g = 0; g < 2; g++) begin : g_chan
      logic             s1;
      logic             s2;
      db_state_t        state;
      db_state_t        state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             accept;
      logic             lvl_q;
      logic             evt_q;

      // Two-flop synchroniser: the raw button is asynchronous to clk_1.
      always_ff @(posedge clk_1 or posedge rst) begin
         // NOTE: non-blocking assignments keep s2 reading last cycle's s1, giving two real flops.
         if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
         end else begin
            s1 <= btn[g];
            s2 <= s1;
         end
      end

      // State register: debounce FSM state and its stability counter.
      always_ff @(posedge clk_1 or posedge rst) begin
         if (rst) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
         end
      end

      // Next-state logic: a level must hold DB_CYCLES cycles after entering a wait state.
      always_comb begin
         // NOTE: defaults first so every path assigns both signals and no latch is inferred.
         state_nxt = state;
         cnt_nxt   = cnt;
         case (state)
            IDLE: begin
               if (s2) begin
                  state_nxt = PRESS_WAIT;
                  cnt_nxt   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!s2) begin
                  state_nxt = IDLE;               // glitch rejected
               end else if (cnt == CNT_LAST) begin
                  state_nxt = PRESSED;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!s2) begin
                  state_nxt = RELEASE_WAIT;
                  cnt_nxt   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (s2) begin
                  state_nxt = PRESSED;            // release bounce, no new press
               end else if (cnt == CNT_LAST) begin
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      // Output decode: a press is accepted on the PRESS_WAIT -> PRESSED edge.
      always_comb begin
         accept = (state == PRESS_WAIT) && s2 && (cnt == CNT_LAST);
      end

      // Registered level and pulse; lock suppresses both but the press is still consumed.
      always_ff @(posedge clk_1 or posedge rst) begin
         if (rst) begin
            lvl_q <= LVL_INIT[g];
            evt_q <= 1'b0;
         end else begin
            lvl_q <= lvl_q ^ (accept & ~lock);
            evt_q <= accept & ~lock;
         end
      end

      assign lvl[g] = lvl_q;
      assign evt[g] = evt_q;
   end

   assign x         = lvl[0];
   assign switch    = lvl[1];
   assign speed_evt = evt[0];
   assign dir_evt   = evt[1];

endmodule

// File: tb/tb_counter_input_ctrl.sv
// tb_counter_input_ctrl: directed scenarios plus random button traffic, checked
// every cycle against a run-length reference model of the debounced buttons.
module tb_counter_input_ctrl;

   localparam int unsigned DB      = 4;
   localparam bit          X_INIT  = 1'b0;
   localparam bit          SW_INIT = 1'b0;

   logic clk_1 = 1'b0;
   logic rst;
   logic btn_speed;
   logic btn_dir;
   logic lock;
   logic x;
   logic switch;
   logic speed_evt;
   logic dir_evt;

   int total = 0;
   int bad   = 0;

   counter_input_ctrl #(
      .DB_CYCLES (DB),
      .CNT_W     (8),
      .X_INIT    (X_INIT),
      .SW_INIT   (SW_INIT)
   ) dut (
      .clk_1     (clk_1),
      .rst       (rst),
      .btn_speed (btn_speed),
      .btn_dir   (btn_dir),
      .lock      (lock),
      .x         (x),
      .switch    (switch),
      .speed_evt (speed_evt),
      .dir_evt   (dir_evt)
   );

   always #5 clk_1 = ~clk_1;

   // Reference model, per button (0 = speed, 1 = dir). A button's debounced
   // level flips once DB+1 consecutive clock samples, taken two edges late,
   // all disagree with it. A flip to pressed toggles the output and pulses evt
   // unless lock was high on that edge.
   bit m_d0   [2];   // raw value seen two edges ago
   bit m_d1   [2];   // raw value seen one edge ago
   bit m_last [2];
   int m_run  [2];
   bit m_deb  [2];
   bit m_out  [2];
   bit m_evt  [2];

   task automatic check(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_d0[i]   = 1'b0;
         m_d1[i]   = 1'b0;
         m_last[i] = 1'b0;
         m_run[i]  = 0;
         m_deb[i]  = 1'b0;
         m_evt[i]  = 1'b0;
      end
      m_out[0] = X_INIT;
      m_out[1] = SW_INIT;
   endtask

   task automatic model_edge(input bit bs, input bit bd, input bit lk);
      bit raw [2];
      bit samp;
      raw[0] = bs;
      raw[1] = bd;
      for (int i = 0; i < 2; i++) begin
         samp    = m_d0[i];
         m_d0[i] = m_d1[i];
         m_d1[i] = raw[i];
         m_run[i] = (samp == m_last[i]) ? m_run[i] + 1 : 1;
         m_last[i] = samp;
         m_evt[i]  = 1'b0;
         if (m_run[i] >= int'(DB) + 1 && samp != m_deb[i]) begin
            m_deb[i] = samp;
            if (samp && !lk) begin
               m_out[i] = ~m_out[i];
               m_evt[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".x"},         x,         m_out[0]);
      check({tag, ".switch"},    switch,    m_out[1]);
      check({tag, ".speed_evt"}, speed_evt, m_evt[0]);
      check({tag, ".dir_evt"},   dir_evt,   m_evt[1]);
   endtask

   // One clock: drive after the falling edge, model the rising edge, check at the next falling edge.
   task automatic step(input string tag, input logic bs, input logic bd, input logic lk);
      btn_speed = bs;
      btn_dir   = bd;
      lock      = lk;
      @(posedge clk_1);
      model_edge(bs, bd, lk);
      @(negedge clk_1);
      check_all(tag);
   endtask

   task automatic hold(input string tag, input int n, input logic bs, input logic bd, input logic lk);
      for (int i = 0; i < n; i++) step(tag, bs, bd, lk);
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      model_reset();
      #1;
      check({tag, ".x"},         x,         X_INIT);
      check({tag, ".switch"},    switch,    SW_INIT);
      check({tag, ".speed_evt"}, speed_evt, 1'b0);
      check({tag, ".dir_evt"},   dir_evt,   1'b0);
      @(posedge clk_1);
      @(negedge clk_1);
      rst = 1'b0;
   endtask

   initial begin
      int  speed_left;
      int  dir_left;
      bit  speed_lvl;
      bit  dir_lvl;

      rst       = 1'b1;
      btn_speed = 1'b0;
      btn_dir   = 1'b0;
      lock      = 1'b0;
      model_reset();
      #12;
      @(negedge clk_1);
      check_all("por");
      rst = 1'b0;

      // Speed press held 20 cycles: toggle on edge 7, single pulse.
      hold("speed_hold", 6, 1'b1, 1'b0, 1'b0);
      check("lat_before7", x, 1'b0);
      step("speed_hold", 1'b1, 1'b0, 1'b0);
      check("lat_at7_x",   x,         1'b1);
      check("lat_at7_evt", speed_evt, 1'b1);
      hold("speed_hold", 13, 1'b1, 1'b0, 1'b0);
      hold("speed_rel", 10, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a second speed press discards its progress.
      hold("speed_part", 5, 1'b1, 1'b0, 1'b0);
      pulse_reset("rst_mid");
      hold("after_rst", 6, 1'b1, 1'b0, 1'b0);
      check("rst_requal", x, 1'b0);
      hold("after_rst", 4, 1'b1, 1'b0, 1'b0);
      hold("after_rst", 10, 1'b0, 1'b0, 1'b0);

      // Direction bounce 1,0,1,0 is rejected.
      step("dir_bounce", 1'b0, 1'b1, 1'b0);
      step("dir_bounce", 1'b0, 1'b0, 1'b0);
      step("dir_bounce", 1'b0, 1'b1, 1'b0);
      hold("dir_bounce", 10, 1'b0, 1'b0, 1'b0);
      check("bounce_sw", switch, SW_INIT);

      // Press-release-press, then a release with a one-cycle bounce.
      hold("dir_p1", 10, 1'b0, 1'b1, 1'b0);
      hold("dir_r1", 10, 1'b0, 1'b0, 1'b0);
      hold("dir_p2", 10, 1'b0, 1'b1, 1'b0);
      hold("dir_r2", 3,  1'b0, 1'b0, 1'b0);
      step("dir_r2b", 1'b0, 1'b1, 1'b0);
      hold("dir_r2", 10, 1'b0, 1'b0, 1'b0);
      check("ppr_sw", switch, SW_INIT);

      // Both buttons together.
      hold("both", 6, 1'b1, 1'b1, 1'b0);
      step("both", 1'b1, 1'b1, 1'b0);
      check("both_spd_evt", speed_evt, 1'b1);
      check("both_dir_evt", dir_evt,   1'b1);
      hold("both", 5, 1'b1, 1'b1, 1'b0);
      hold("both_rel", 10, 1'b0, 1'b0, 1'b0);

      // Lock during acceptance consumes the press; releasing lock while held does nothing.
      hold("lock_on", 9, 1'b1, 1'b0, 1'b1);
      check("lock_no_evt", speed_evt, 1'b0);
      hold("lock_off_held", 8, 1'b1, 1'b0, 1'b0);
      hold("lock_rel", 10, 1'b0, 1'b0, 1'b0);
      hold("lock_repress", 10, 1'b1, 1'b0, 1'b0);
      hold("lock_rel2", 10, 1'b0, 1'b0, 1'b0);

      // Random traffic: per-button levels held for random lengths, occasional lock.
      speed_left = 0;
      dir_left   = 0;
      speed_lvl  = 1'b0;
      dir_lvl    = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (speed_left == 0) begin
            speed_lvl  = ~speed_lvl;
            speed_left = $urandom_range(1, 12);
         end
         if (dir_left == 0) begin
            dir_lvl  = ~dir_lvl;
            dir_left = $urandom_range(1, 12);
         end
         step("rand", speed_lvl, dir_lvl, ($urandom_range(0, 7) == 0));
         speed_left--;
         dir_left--;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
